display_scan_mux: RTL and testbench

- Time-multiplexes four snapshotted BCD digits onto the shared 4-digit seven-segment display.
- Drives the downstream decoder's 2-bit digit select `en` and 4-bit BCD value `digit`.
- Adds per-digit blinking for alarm/time-set mode and blanking of invalid codes.
- Sits between the clock/alarm time registers and the seven-segment decoder.

---
 rtl/display_pkg.sv | 24 ++
 rtl/refresh_prescaler.sv | 34 +++
 rtl/display_scan_mux.sv | 99 +++++++++
 tb/tb_display_scan_mux.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// ==========================================================================
// display_pkg: shared constants and slot/nibble mapping for the display path
// Revision: 1.0
// ==========================================================================
`default_nettype none

package display_pkg;

  localparam int         NUM_SLOTS      = 4;
  localparam logic [3:0] BCD_MAX        = 4'd9;

  localparam logic [1:0] SLOT_LEFT      = 2'd0;
  localparam logic [1:0] SLOT_MID_LEFT  = 2'd1;
  localparam logic [1:0] SLOT_MID_RIGHT = 2'd2;
  localparam logic [1:0] SLOT_RIGHT     = 2'd3;

  // Slot 0 is the leftmost digit, which lives in the most significant nibble.
  function automatic logic [1:0] nibble_index(input logic [1:0] slot);
    return 2'(NUM_SLOTS - 1) - slot;
  endfunction

endpackage

`default_nettype wire

// File: rtl/refresh_prescaler.sv
// ==========================================================================
// refresh_prescaler: free-running divider, tick high on count DIV-1
// Revision: 1.0
// ==========================================================================
`default_nettype none

module refresh_prescaler #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/display_scan_mux.sv
// ==========================================================================
// display_scan_mux: 4-digit scan multiplexer with snapshot, blink, blanking
// Optional: define LEADING_ZERO_BLANK_EN to blank a zero in the leftmost slot
// Revision: 1.0
// ==========================================================================
`default_nettype none

module display_scan_mux
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic [3:0]  blink_mask,
  output logic [1:0]  en,
  output logic [3:0]  digit,
  output logic        blank,
  output logic        frame_start
);

  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic           tick;
  logic           wrap;
  logic [15:0]    snap;
  logic [3:0]     snap_mask;
  logic [FCW-1:0] frame_cnt;
  logic           frame_last;
  logic           blink_phase;
  logic           next_phase;
  logic [1:0]     next_slot;
  logic [1:0]     src_idx;
  logic [15:0]    src_digits;
  logic [3:0]     src_mask;
  logic [3:0]     next_digit;
  logic           next_blank;

  refresh_prescaler #(
    .DIV   (REFRESH_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign wrap       = tick && (en == SLOT_RIGHT);
  assign next_slot  = en + 2'd1;
  assign frame_last = (frame_cnt == FCW'(BLINK_FRAMES - 1));
  assign next_phase = (wrap && frame_last) ? ~blink_phase : blink_phase;

  // The first slot of a new frame bypasses the snapshot so input changes
  // landing at the frame boundary are shown without a frame of lag.
  assign src_digits = wrap ? digits_in  : snap;
  assign src_mask   = wrap ? blink_mask : snap_mask;
  assign src_idx    = nibble_index(next_slot);

  always_comb begin
    next_digit = src_digits[{src_idx, 2'b00} +: 4];
    next_blank = (next_digit > BCD_MAX) || (src_mask[src_idx] && next_phase);
`ifdef LEADING_ZERO_BLANK_EN
    if ((next_slot == SLOT_LEFT) && (next_digit == 4'd0)) begin
      next_blank = 1'b1;
    end
`else
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en          <= SLOT_LEFT;
      digit       <= 4'd0;
      blank       <= 1'b0;
      frame_start <= 1'b0;
      snap        <= 16'd0;
      snap_mask   <= 4'd0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick) begin
        en    <= next_slot;
        digit <= next_digit;
        blank <= next_blank;
      end
      if (wrap) begin
        snap        <= digits_in;
        snap_mask   <= blink_mask;
        blink_phase <= next_phase;
        frame_cnt   <= frame_last ? '0 : frame_cnt + FCW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_scan_mux.sv
// ==========================================================================
// tb_display_scan_mux: directed checks of display_scan_mux (DIV=4 and DIV=1)
// Revision: 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_display_scan_mux;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic LZ = 1'b1;
`else
  localparam logic LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits_in = 16'h1234;
  logic [3:0]  blink_mask = 4'd0;
  logic [1:0]  en;
  logic [3:0]  digit;
  logic        blank;
  logic        frame_start;

  logic [15:0] digits_fast = 16'h0905;
  logic [3:0]  mask_fast = 4'd0;
  logic [1:0]  en_fast;
  logic [3:0]  digit_fast;
  logic        blank_fast;
  logic        fs_fast;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] din;
    logic [3:0]  bl;   // bit k = expected blank for slot k
    string       name;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  display_scan_mux #(
    .REFRESH_DIV (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits_in   (digits_in),
    .blink_mask  (blink_mask),
    .en          (en),
    .digit       (digit),
    .blank       (blank),
    .frame_start (frame_start)
  );

  display_scan_mux #(
    .REFRESH_DIV (1),
    .BLINK_FRAMES(2)
  ) dut_fast (
    .clk         (clk),
    .reset       (reset),
    .digits_in   (digits_fast),
    .blink_mask  (mask_fast),
    .en          (en_fast),
    .digit       (digit_fast),
    .blank       (blank_fast),
    .frame_start (fs_fast)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Starts at the sample point of slot 0 cycle 0 and ends on the next frame's first sample.
  task automatic check_frame(input string name, input logic [15:0] exp_digits,
                             input logic [3:0] bl, input logic fs_first,
                             input int chg_at, input logic [15:0] chg_val);
    int          k;
    logic [3:0]  nib;
    logic [7:0]  exp;
    for (int i = 0; i < 16; i++) begin
      k = i / 4;
      if (i == chg_at) digits_in = chg_val;
      nib = exp_digits[4*(3-k) +: 4];
      exp = {2'(k), nib, bl[k], (i == 0) ? fs_first : 1'b0};
      check($sformatf("%s slot%0d cyc%0d {en,digit,blank,fs}", name, k, i % 4),
            {24'd0, en, digit, blank, frame_start}, {24'd0, exp});
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] prev_d;
    logic [3:0]  prev_bl;
    bit          found;

    vecs[0] = '{16'h12A4, 4'b0100,          "bcd_A_slot2"};
    vecs[1] = '{16'hF000, 4'b0001,          "bcd_F_slot0"};
    vecs[2] = '{16'h0905, {3'b000, LZ},     "lead_zero"};
    vecs[3] = '{16'h9999, 4'b0000,          "all_nine"};
    vecs[4] = '{16'h0A00, {2'b00, 1'b1, LZ}, "bcd_A_slot1"};
    vecs[5] = '{16'h1234, 4'b0000,          "back_1234"};

    repeat (3) @(negedge clk);
    check("reset_outputs", {24'd0, en, digit, blank, frame_start}, 32'd0);

    // Reset frame shows the cleared snapshot, then the live value.
    reset = 1'b0;
    check_frame("rst_frame", 16'h0000, 4'b0000, 1'b0, -1, 16'h0);
    check_frame("f1234", 16'h1234, 4'b0000, 1'b1, -1, 16'h0);
    check_frame("no_tear", 16'h1234, 4'b0000, 1'b1, 4, 16'h5678);
    check_frame("f5678", 16'h5678, 4'b0000, 1'b1, -1, 16'h0);

    prev_d  = 16'h5678;
    prev_bl = 4'b0000;
    for (int v = 0; v < 6; v++) begin
      digits_in = vecs[v].din;
      check_frame({vecs[v].name, "_old"}, prev_d, prev_bl, 1'b1, -1, 16'h0);
      check_frame(vecs[v].name, vecs[v].din, vecs[v].bl, 1'b1, -1, 16'h0);
      prev_d  = vecs[v].din;
      prev_bl = vecs[v].bl;
    end

    // Asynchronous reset in slot 2.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (en == 2'd2) found = 1'b1;
      else @(negedge clk);
    end
    check("wait_en2_found", {31'd0, found}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {24'd0, en, digit, blank, frame_start}, 32'd0);
    digits_in  = 16'h1234;
    blink_mask = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    check_frame("blink_rst", 16'h0000, 4'b0000, 1'b0, -1, 16'h0);
    check_frame("blink_f1", 16'h1234, 4'b0000, 1'b1, -1, 16'h0);
    check_frame("blink_f2", 16'h1234, 4'b0001, 1'b1, -1, 16'h0);
    check_frame("blink_f3", 16'h1234, 4'b0001, 1'b1, -1, 16'h0);
    check_frame("blink_f4", 16'h1234, 4'b0000, 1'b1, -1, 16'h0);
    check_frame("blink_f5", 16'h1234, 4'b0000, 1'b1, -1, 16'h0);
    check_frame("blink_f6", 16'h1234, 4'b0001, 1'b1, -1, 16'h0);

    // REFRESH_DIV=1 instance: one slot per cycle.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (fs_fast) found = 1'b1;
      else @(negedge clk);
    end
    check("fast_fs_found", {31'd0, found}, 32'd1);
    check("fast_slot0", {24'd0, en_fast, digit_fast, blank_fast, fs_fast},
          {24'd0, 2'd0, 4'd0, LZ, 1'b1});
    @(negedge clk);
    check("fast_slot1", {24'd0, en_fast, digit_fast, blank_fast, fs_fast},
          {24'd0, 2'd1, 4'd9, 1'b0, 1'b0});
    @(negedge clk);
    check("fast_slot2", {24'd0, en_fast, digit_fast, blank_fast, fs_fast},
          {24'd0, 2'd2, 4'd0, 1'b0, 1'b0});
    @(negedge clk);
    check("fast_slot3", {24'd0, en_fast, digit_fast, blank_fast, fs_fast},
          {24'd0, 2'd3, 4'd5, 1'b0, 1'b0});
    @(negedge clk);
    check("fast_wrap", {24'd0, en_fast, digit_fast, blank_fast, fs_fast},
          {24'd0, 2'd0, 4'd0, LZ, 1'b1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
